par2ser_feeder: RTL and testbench

//  Parallel-to-serial front end for the SeqLogic shift-register chain.

---
 rtl/par2ser_pkg.sv | 17 +
 rtl/par2ser_bitcnt.sv | 27 ++
 rtl/par2ser_feeder.sv | 134 +++++++++++++
 tb/tb_par2ser_feeder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/par2ser_pkg.sv
// Shared types and sizing helpers for the par2ser_feeder front end.
package par2ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int GAP_W = 8;

  // Bit counter width: must hold WIDTH+1 (parity build) with headroom.
  function automatic int cnt_w(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/par2ser_bitcnt.sv
// Loadable down-counter; tc flags the final count (cnt == 1).
module par2ser_bitcnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == W'(1));

endmodule

// File: rtl/par2ser_feeder.sv
// Parallel-to-serial feeder for the serial shift-register chain.
// Optional build macro PAR2SER_PARITY_EN appends one even-parity bit per word.
module par2ser_feeder
  import par2ser_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_dout,
  output logic             ser_shift_en,
  output logic             busy,
  output logic             done
);

`ifdef PAR2SER_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(NBITS);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

  state_t           state;
  logic [NBITS-1:0] shadow;
  logic [NBITS-1:0] word_seq;
  logic             rdy_en;
  logic             accept;
  logic             bit_last;
  logic             gap_last;

  // Put the word in transmit order so the shadow always shifts out of its top bit.
  function automatic logic [WIDTH-1:0] order_bits(input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    return MSB_FIRST ? d : r;
  endfunction

  always_comb begin
`ifdef PAR2SER_PARITY_EN
    word_seq = {order_bits(in_data), ^in_data};
`else
    word_seq = order_bits(in_data);
`endif
  end

  // rdy_en holds in_ready low through the first edge after reset release.
  assign in_ready = rdy_en & ((state == IDLE) |
                              (!HAS_GAP & (state == SHIFT) & bit_last));
  assign accept   = in_valid & in_ready;

  par2ser_bitcnt #(.W(CNT_W)) u_bitcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .load_val (BIT_LOAD),
    .dec      (state == SHIFT),
    .tc       (bit_last)
  );

  par2ser_bitcnt #(.W(GAP_W)) u_gapcnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     ((state == SHIFT) & bit_last & ~accept),
    .load_val (GAP_LOAD),
    .dec      (state == GAP),
    .tc       (gap_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rdy_en       <= 1'b0;
      shadow       <= '0;
      ser_dout     <= 1'b0;
      ser_shift_en <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      done   <= 1'b0;
      if (accept) begin
        // A reload from SHIFT is the back-to-back case: the finished word still signals done.
        done         <= (state == SHIFT);
        state        <= SHIFT;
        busy         <= 1'b1;
        ser_shift_en <= 1'b1;
        ser_dout     <= word_seq[NBITS-1];
        shadow       <= word_seq << 1;
      end else begin
        unique case (state)
          IDLE: begin
            ser_shift_en <= 1'b0;
            ser_dout     <= 1'b0;
            busy         <= 1'b0;
          end
          SHIFT: begin
            if (bit_last) begin
              done         <= 1'b1;
              ser_shift_en <= 1'b0;
              ser_dout     <= 1'b0;
              state        <= HAS_GAP ? GAP : IDLE;
              busy         <= HAS_GAP;
            end else begin
              ser_dout <= shadow[NBITS-1];
              shadow   <= shadow << 1;
            end
          end
          GAP: begin
            if (gap_last) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state        <= IDLE;
            busy         <= 1'b0;
            ser_shift_en <= 1'b0;
            ser_dout     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_par2ser_feeder.sv
// Directed bench for par2ser_feeder: three instances cover MSB/LSB order and the gap option.
module tb_par2ser_feeder;

`ifdef PAR2SER_PARITY_EN
  localparam bit PAR = 1'b1;
  localparam int NB  = 9;
`else
  localparam bit PAR = 1'b0;
  localparam int NB  = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic [2:0] rdy, sdo, sen, bsy, dn;
  logic [4:0] shift5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         dut;
    logic [7:0] exp;
    logic       par;
  } vec_t;

  vec_t tbl [6];

  // u0: MSB first, no gap; u1: LSB first, no gap; u2: MSB first, 3 gap cycles
  par2ser_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
    .ser_dout(sdo[0]), .ser_shift_en(sen[0]), .busy(bsy[0]), .done(dn[0]));
  par2ser_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
    .ser_dout(sdo[1]), .ser_shift_en(sen[1]), .busy(bsy[1]), .done(dn[1]));
  par2ser_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(3)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[2]),
    .ser_dout(sdo[2]), .ser_shift_en(sen[2]), .busy(bsy[2]), .done(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream 5-bit shift register fed by u0.
  initial shift5 = '0;
  always @(posedge clk) if (sen[0] === 1'b1) shift5 <= {shift5[3:0], sdo[0]};

  function automatic logic [8:0] full(input logic [7:0] e, input logic p);
    return PAR ? {e, p} : {1'b0, e};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_rdy(input int d);
    int n;
    n = 0;
    while (rdy[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout dut=%0d actual=0 required=1", d);
    end
  endtask

  // Hold word until accepted; returns at the first bit cycle.
  task automatic send(input int d, input logic [7:0] data);
    in_data  = data;
    in_valid = 1'b1;
    wait_rdy(d);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(input int d, output logic [8:0] got, output logic ok);
    got = '0;
    ok  = 1'b1;
    for (int i = 0; i < NB; i++) begin
      if (sen[d] !== 1'b1) ok = 1'b0;
      got = {got[7:0], sdo[d]};
      @(negedge clk);
    end
  endtask

  initial begin
    logic [8:0]  got;
    logic        ok;
    logic [17:0] got2, exp2;
    logic [8:0]  rdyv;
    int          dones, zeros, gapc, n;
    logic        seen;

    tbl[0] = '{8'hA5, 0, 8'hA5, 1'b0};
    tbl[1] = '{8'h3C, 0, 8'h3C, 1'b0};
    tbl[2] = '{8'h01, 1, 8'h80, 1'b1};
    tbl[3] = '{8'h80, 1, 8'h01, 1'b1};
    tbl[4] = '{8'hC8, 1, 8'h13, 1'b1};
    tbl[5] = '{8'hF0, 2, 8'hF0, 1'b0};

    // Reset, then release with in_valid already high: no accept at that edge.
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {rdy, sdo, sen, bsy, dn}, 15'h0);
    in_data = 8'hFF; in_valid = 1'b1; rst_n = 1'b1;
    @(negedge clk);
    chk("no_accept_at_release", {rdy[0], sen[0], bsy[0]}, 3'b100);
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_state", {rdy[0], sen[0], bsy[0], dn[0]}, 4'b1000);
    end

    // Table of single words.
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].dut, tbl[i].data);
      collect(tbl[i].dut, got, ok);
      chk($sformatf("stream_%0d", i), 32'(got), 32'(full(tbl[i].exp, tbl[i].par)));
      chk($sformatf("contiguous_%0d", i), 32'(ok), 32'd1);
      chk($sformatf("done_after_%0d", i), {dn[tbl[i].dut], sen[tbl[i].dut]}, 2'b10);
      if (i == 0) chk("downstream5", 32'(shift5), PAR ? 32'h0A : 32'h05);
    end

    // Back-to-back on u1; in_data changed mid-word must not disturb the first word.
    in_data = 8'h01; in_valid = 1'b1;
    wait_rdy(1);
    @(negedge clk);
    in_data = 8'h80;
    got2 = '0; rdyv = '0; dones = 0; ok = 1'b1;
    for (int i = 0; i < 2 * NB; i++) begin
      if (i == NB) in_valid = 1'b0;
      if (sen[1] !== 1'b1) ok = 1'b0;
      if (i < NB) rdyv = {rdyv[7:0], rdy[1]};
      if (dn[1] === 1'b1) dones++;
      got2 = {got2[16:0], sdo[1]};
      @(negedge clk);
    end
    if (dn[1] === 1'b1) dones++;
    exp2 = ({9'b0, full(8'h80, 1'b1)} << NB) | {9'b0, full(8'h01, 1'b1)};
    chk("b2b_stream", 32'(got2), 32'(exp2));
    chk("b2b_contiguous", 32'(ok), 32'd1);
    chk("b2b_ready_last_only", 32'(rdyv), 32'd1);
    chk("b2b_done_count", 32'(dones), 32'd2);
    chk("b2b_end_idle", 32'(sen[1]), 32'd0);

    // Gap of three cycles on u2 between two words.
    in_data = 8'hC3; in_valid = 1'b1;
    wait_rdy(2);
    @(negedge clk);
    in_data = 8'h3C;
    collect(2, got, ok);
    chk("gap_w1_stream", 32'(got), 32'(full(8'hC3, 1'b0)));
    chk("gap_done", 32'(dn[2]), 32'd1);
    zeros = 0; gapc = 0; n = 0;
    while (sen[2] !== 1'b1 && n < 20) begin
      zeros++;
      if (bsy[2] === 1'b1 && rdy[2] === 1'b0) gapc++;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("gap_busy_cycles", 32'(gapc), 32'd3);
    chk("gap_zero_cycles", 32'(zeros), 32'd4);
    collect(2, got, ok);
    chk("gap_w2_stream", 32'(got), 32'(full(8'h3C, 1'b0)));
    chk("gap_w2_contiguous", 32'(ok), 32'd1);

    // Asynchronous reset in the middle of 8'hFF.
    send(0, 8'hFF);
    repeat (4) @(negedge clk);
    chk("abort_midword", 32'(sen[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("abort_async_outputs", {rdy[0], sdo[0], sen[0], bsy[0], dn[0]}, 5'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (dn[0] === 1'b1 || sen[0] === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    send(0, 8'h96);
    collect(0, got, ok);
    chk("after_abort_stream", 32'(got), 32'(full(8'h96, 1'b0)));
    chk("after_abort_done", {dn[0], sen[0]}, 2'b10);

`ifdef PAR2SER_PARITY_EN
    send(0, 8'h07);
    collect(0, got, ok);
    chk("parity_07_bit", 32'(got[0]), 32'd1);
    chk("parity_07_stream", 32'(got), 32'h00F);
    send(0, 8'h03);
    collect(0, got, ok);
    chk("parity_03_bit", 32'(got[0]), 32'd0);
    chk("parity_03_done", {dn[0], sen[0]}, 2'b10);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
